// File: rtl/order_ref_map.sv
// Order-reference map: stores add messages under their 64-bit reference and resolves
// delete/execute messages into locate/price/shares/side for the downstream order book.
module order_ref_map #(
    parameter int MAP_DEPTH = 1024
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        addValidIn,
    input  logic        delValidIn,
    input  logic        execValidIn,
    input  logic [63:0] orderRefIn,
    input  logic [15:0] locateIn,
    input  logic [31:0] priceIn,
    input  logic [31:0] sharesIn,
    input  logic        buySellIn,
    output logic        readyOut,
    output logic        mapValidOut,
    output logic [15:0] mapLocateOut,
    output logic [31:0] mapPriceOut,
    output logic [31:0] mapSharesOut,
    output logic        mapBuySellOut,
    output logic        missOut,
    output logic        collisionOut,
    output logic [15:0] missCntOut,
    output logic [15:0] collisionCntOut
);
    localparam int IDX_W = $clog2(MAP_DEPTH);

    typedef struct packed {
        logic [63:0] orderRef;
        logic [15:0] locate;
        logic [31:0] price;
        logic [31:0] shares;
        logic        buySell;
    } entry_t;

    typedef enum logic [1:0] {OP_ADD, OP_DEL, OP_EXE} op_t;
    typedef enum logic {S_INIT, S_RUN} state_t;

    // ---------------- init FSM ----------------
    state_t             r_state, w_nextState;
    logic [IDX_W-1:0]   r_initIdx;
    logic               w_initClr;
    logic               w_ready;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            r_state   <= S_INIT;
            r_initIdx <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_INIT)
                r_initIdx <= r_initIdx + 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_initClr   = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            S_INIT: begin
                w_initClr = 1'b1;
                if (r_initIdx == IDX_W'(MAP_DEPTH - 1))
                    w_nextState = S_RUN;
            end
            S_RUN:   w_ready = 1'b1;
            default: w_nextState = S_INIT;
        endcase
    end

    assign readyOut = w_ready;

    // ---------------- stage 0: accept + table read ----------------
    logic             w_accept;
    op_t              w_op;
    entry_t           w_inMsg;
    logic [IDX_W-1:0] w_rdIdx;

    assign w_accept = w_ready && (addValidIn || delValidIn || execValidIn);
    assign w_op     = addValidIn ? OP_ADD : (delValidIn ? OP_DEL : OP_EXE);
    assign w_rdIdx  = orderRefIn[IDX_W-1:0];
    assign w_inMsg  = '{orderRef: orderRefIn, locate: locateIn, price: priceIn,
                        shares: sharesIn, buySell: buySellIn};

    logic   r_s1Vld;
    op_t    r_s1Op;
    entry_t r_s1Msg;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            r_s1Vld <= 1'b0;
            r_s1Op  <= OP_ADD;
            r_s1Msg <= '0;
        end else begin
            r_s1Vld <= w_accept;
            if (w_accept) begin
                r_s1Op  <= w_op;
                r_s1Msg <= w_inMsg;
            end
        end
    end

    // ---------------- table storage ----------------
    entry_t             r_mem [MAP_DEPTH];
    logic [MAP_DEPTH-1:0] r_validArr;
    entry_t             r_rdEntry;
    logic               r_rdValid;

    logic             w_wrEn;
    entry_t           w_wrEntry;
    logic             w_wrValid;
    logic [IDX_W-1:0] w_s1Idx;

    // Read-old semantics: a same-cycle write is picked up by the forwarding path instead.
    always_ff @(posedge clkIn) begin
        if (w_wrEn)
            r_mem[w_s1Idx] <= w_wrEntry;
        r_rdEntry <= r_mem[w_rdIdx];
    end

    always_ff @(posedge clkIn) begin
        if (w_initClr)
            r_validArr[r_initIdx] <= 1'b0;
        else if (w_wrEn)
            r_validArr[w_s1Idx] <= w_wrValid;
        r_rdValid <= r_validArr[w_rdIdx];
    end

    // ---------------- stage 1: compare, share math, write ----------------
    logic             r_lastWrEn;
    logic [IDX_W-1:0] r_lastIdx;
    entry_t           r_lastEntry;
    logic             r_lastValid;

    logic        w_fwd;
    entry_t      w_cur;
    logic        w_curValid;
    logic        w_refHit;
    logic        w_hit, w_miss, w_coll;
    logic [31:0] w_outShares;
    logic [31:0] w_remain;

    assign w_s1Idx    = r_s1Msg.orderRef[IDX_W-1:0];
    assign w_fwd      = r_lastWrEn && (r_lastIdx == w_s1Idx);
    assign w_cur      = w_fwd ? r_lastEntry : r_rdEntry;
    assign w_curValid = w_fwd ? r_lastValid : r_rdValid;
    assign w_refHit   = w_curValid && (w_cur.orderRef == r_s1Msg.orderRef);
    assign w_remain   = w_cur.shares - w_outShares;

    always_comb begin
        w_wrEn      = 1'b0;
        w_wrEntry   = w_cur;
        w_wrValid   = w_curValid;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_coll      = 1'b0;
        w_outShares = '0;
        if (r_s1Vld) begin
            case (r_s1Op)
                OP_ADD: begin
                    w_wrEn    = 1'b1;
                    w_wrEntry = r_s1Msg;
                    w_wrValid = 1'b1;
                    w_coll    = w_curValid && !w_refHit;
                end
                OP_DEL: begin
                    if (w_refHit) begin
                        w_hit       = 1'b1;
                        w_outShares = w_cur.shares;
                        w_wrEn      = 1'b1;
                        w_wrValid   = 1'b0;
                    end else begin
                        w_miss = 1'b1;
                    end
                end
                default: begin
                    if (w_refHit) begin
                        w_hit       = 1'b1;
                        w_outShares = (r_s1Msg.shares < w_cur.shares) ? r_s1Msg.shares
                                                                      : w_cur.shares;
                        w_wrEn           = 1'b1;
                        w_wrEntry.shares = w_remain;
                        // A zero-share execute leaves the entry untouched, even a 0-share one.
                        w_wrValid = (w_remain != 32'd0) || (w_outShares == 32'd0);
                    end else begin
                        w_miss = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            r_lastWrEn  <= 1'b0;
            r_lastIdx   <= '0;
            r_lastEntry <= '0;
            r_lastValid <= 1'b0;
        end else begin
            r_lastWrEn  <= w_wrEn;
            r_lastIdx   <= w_s1Idx;
            r_lastEntry <= w_wrEntry;
            r_lastValid <= w_wrValid;
        end
    end

    // ---------------- stage 2: registered results ----------------
    logic        r_mapValid, r_miss, r_coll, r_buySell;
    logic [15:0] r_locate, r_missCnt, r_collCnt;
    logic [31:0] r_price, r_shares;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            r_mapValid <= 1'b0;
            r_miss     <= 1'b0;
            r_coll     <= 1'b0;
            r_locate   <= '0;
            r_price    <= '0;
            r_shares   <= '0;
            r_buySell  <= 1'b0;
            r_missCnt  <= '0;
            r_collCnt  <= '0;
        end else begin
            r_mapValid <= w_hit;
            r_miss     <= w_miss;
            r_coll     <= w_coll;
            if (w_hit) begin
                r_locate  <= w_cur.locate;
                r_price   <= w_cur.price;
                r_shares  <= w_outShares;
                r_buySell <= w_cur.buySell;
            end
            if (w_miss && (r_missCnt != 16'hFFFF))
                r_missCnt <= r_missCnt + 16'd1;
            if (w_coll && (r_collCnt != 16'hFFFF))
                r_collCnt <= r_collCnt + 16'd1;
        end
    end

    assign mapValidOut     = r_mapValid;
    assign missOut         = r_miss;
    assign collisionOut    = r_coll;
    assign mapLocateOut    = r_locate;
    assign mapPriceOut     = r_price;
    assign mapSharesOut    = r_shares;
    assign mapBuySellOut   = r_buySell;
    assign missCntOut      = r_missCnt;
    assign collisionCntOut = r_collCnt;

endmodule

// File: doc/order_ref_map.md
# order_ref_map

Order-reference map sitting directly upstream of the order book on the delete/execute path. Add messages store their locate, price, shares and side under their 64-bit order reference number. Delete and execute messages carry only a reference. For those, the block recovers the stored order, computes the shares to remove, and updates or frees the entry. It then presents the result to the book's `mapLocateIn`/`mapPriceIn`/`mapSharesIn`/`mapBuySellIn`/`delExecValidIn` inputs.

## Interface
- `MAP_DEPTH`, 1024: table entries; power of two, ≥ 4. `IDX_W = $clog2(MAP_DEPTH)`.
- `clkIn`  in  1  single clock for the whole block.
- `rstIn`  in  1  reset, asynchronous, active-low.
- `addValidIn`  in  1  add message strobe.
- `delValidIn`  in  1  delete message strobe.
- `execValidIn`  in  1  execute message strobe.
- `orderRefIn`  in  64  order reference for add, delete or execute.
- `locateIn`  in  16  add: stock locate.
- `priceIn`  in  32  add: price.
- `sharesIn`  in  32  add: shares; execute: executed shares.
- `buySellIn`  in  1  add: 1 = buy.
- `readyOut`  out  1  high once init sweep is done; strobes are ignored while low.
- `mapValidOut`  out  1  one-cycle pulse: a delete/execute hit is being reported.
- `mapLocateOut`  out  16  stored locate.
- `mapPriceOut`  out  32  stored price.
- `mapSharesOut`  out  32  shares removed from the book.
- `mapBuySellOut`  out  1  stored side.
- `missOut`  out  1  one-cycle pulse: delete/execute reference not found.
- `collisionOut`  out  1  one-cycle pulse: add overwrote a live entry with a different reference.
- `missCntOut`  out  16  saturating miss count.
- `collisionCntOut`  out  16  saturating collision count.

## Operation
- Table layout:
  - Direct-mapped, indexed by `orderRefIn[IDX_W-1:0]`.
  - Entry = {valid, ref[63:0], locate, price, remaining shares, side}.
  - Implemented as synchronous-read block RAM plus a valid-bit array.
- FSM states:
  - INIT: entered on reset. Sweeps index 0..`MAP_DEPTH`-1 clearing valid, one index per cycle. `readyOut` = 0.
  - RUN: entered after the last index is cleared. `readyOut` = 1.
- Add:
  - Writes the entry with valid = 1, remaining = `sharesIn`.
  - If the slot was valid with a different ref: pulse `collisionOut` and increment `collisionCntOut`. The new order wins.
  - Same ref re-added: overwrite silently.
- Delete on hit (valid and ref match):
  - Report stored fields with `mapSharesOut` = remaining.
  - Clear valid.
- Execute on hit:
  - `mapSharesOut` = min(`sharesIn`, remaining).
  - remaining -= `mapSharesOut`.
  - If remaining reaches 0, clear valid.
- Miss (delete or execute):
  - No table change, no `mapValidOut`.
  - Pulse `missOut` and increment `missCntOut`.
- Zero-share execute on hit: `mapValidOut` pulses with `mapSharesOut` = 0; entry unchanged.
- Strobe precedence when more than one is high: add > delete > execute; lower-priority strobes are dropped.
- Arithmetic:
  - 32-bit unsigned, no wrap; the clamp prevents underflow.
  - Counters saturate at 16'hFFFF.

## Timing
- Throughput: one message per cycle in RUN.
- Pipeline, for a strobe accepted in cycle T:
  - T: table read issued.
  - T+1: tag compare, share math, table write.
  - T+2: `mapValidOut`/`missOut`/`collisionOut` and data registered and valid.
- Latency is exactly 2 cycles for every message type.
- Hazard rule: an op in T+1 whose index matches the op one cycle older must use that op's written value (forwarding). Back-to-back operations on the same reference behave exactly as if serialized.
- Output data holds its last value when `mapValidOut` = 0.
- Reset values: all outputs 0; `readyOut` = 0; FSM = INIT.
- INIT lasts exactly `MAP_DEPTH` cycles after reset release.
- Reset asserted mid-operation:
  - In-flight ops are discarded and no pulses are emitted.
  - Counters clear.
  - INIT restarts.

## Test plan
- Reset release → `readyOut` low for 1024 cycles, then high. Delete ref 5 → `missOut` at T+2, `missCntOut` = 1.
- Add ref 0x10, locate 7, price 1000, shares 300, buy; then delete 0x10 → at T+2: `mapValidOut`, locate 7, price 1000, shares 300, side 1. A second delete of 0x10 → miss.
- Add ref 0x20 with 500 shares; exec 200; exec 200; exec 200 on consecutive cycles → `mapSharesOut` 200, 200, 100. A fourth exec → miss.
- Add ref 0x30, then add ref 0x30+1024 → `collisionOut` pulse and `collisionCntOut` = 1. Delete 0x30 → miss. Delete 0x430 → hit.
- Add and execute of the same ref in adjacent cycles, then execute in the very next cycle → forwarding is correct: second exec sees the decremented remaining.
- Assert `rstIn` while 2 ops are in flight → no output pulses, counters 0, INIT re-runs for the full sweep.
